bht_arbiter: RTL and testbench
==============================

Name: bht_arbiter

Overview:
- Branch history table: 2^INDEX_W two-bit saturating counters behind a single access slot.
- The slot is shared by two requesters: the fetch-side lookup port and the execute-side resolve/update port.
- Updates are buffered in a small FIFO. Lookups have priority, with a starvation guard so updates always drain.
- Sits between fetch (prediction consumer) and branch resolution (outcome producer).

Parameters:
- INDEX_W, 4, table index width; table has 2^INDEX_W entries.
- UQ_DEPTH, 4, update queue depth in entries (power of 2, ≥2).
- STARVE_MAX, 3, max consecutive granted lookups while the queue is non-empty before an update is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_valid  in  1  fetch requests a prediction.
- lookup_index  in  INDEX_W  table index for the lookup.
- lookup_ready  out  1  lookup accepted this cycle when lookup_valid && lookup_ready.
- resp_valid  out  1  prediction valid; one-cycle pulse.
- resp_prediction  out  1  1 = taken, 0 = not taken.
- upd_valid  in  1  resolved branch outcome offered.
- upd_index  in  INDEX_W  table index to train.
- upd_taken  in  1  actual outcome.
- upd_ready  out  1  queue can accept; equals !full.
- uq_count  out  $clog2(UQ_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all counters = 2'b00; queue emptied; starve_cnt = 0.
  - resp_valid = 0, resp_prediction = 0, uq_count = 0, upd_ready = 1.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken. Prediction = counter[1].
- Training:
  - taken: 00→01→10→11, saturating at 11.
  - not taken: 11→10→01→00, saturating at 00.
- Enqueue: when upd_valid && upd_ready, push {upd_index, upd_taken}.
  - When full, upd_ready = 0 even if a dequeue occurs the same cycle (no pass-through).
- force_upd = queue non-empty && (full || starve_cnt == STARVE_MAX).
- lookup_ready = !force_upd. This is combinational from registered state only; it never depends on lookup_valid.
- Per-cycle slot grant, exactly one of:
  - LOOKUP: lookup_valid && lookup_ready. Read counter[lookup_index]. Next cycle: resp_valid = 1, resp_prediction = counter[1] as it was in the grant cycle. Latency = 1 cycle.
  - UPDATE: queue non-empty && not LOOKUP. Pop the head entry and read-modify-write its counter in the same cycle; the new value is visible to a lookup granted the next cycle.
  - IDLE: neither.
- starve_cnt:
  - +1 on a LOOKUP grant while the queue is non-empty, saturating at STARVE_MAX.
  - cleared on an UPDATE grant or whenever the queue is empty.
- No forwarding: a lookup to an index with a pending queued update returns the stale table value.
- uq_count:
  - +1 on enqueue only; −1 on dequeue only; unchanged when both or neither occur.
  - Registered; reflects state after the clock edge.
- Same-cycle enqueue into an empty queue: the entry becomes eligible for UPDATE the next cycle.
- resp_valid is 0 in every cycle not immediately following a LOOKUP grant; resp_prediction holds its last value.
- FIFO pointers: log2(UQ_DEPTH) bits, natural wrap-around.

Decomposition:
- Shared package (bp_pkg):
  - 2-bit counter state constants (SNT = 00, WNT = 01, WT = 10, ST = 11).
  - Update-entry struct {index, taken}.
  - next_counter(state, taken) saturating function, reused by the existing predictor.
- One sub-module: bht_upd_fifo.
  - Parametric FIFO with push/pop, full/empty, count, async active-high reset.
- The arbiter, starvation counter and counter array live in bht_arbiter.

Test Plan:
1. Reset, then lookup idx 5 → lookup_ready = 1; next cycle resp_valid = 1, resp_prediction = 0. uq_count = 0.
2. Enqueue 2 taken updates to idx 3 with no lookups → drained in 2 cycles. Counter = 10; lookup idx 3 then returns 1. A third taken update, then 3 more taken, leaves counter at 11 (saturation). 4 not-taken updates → 00; a 5th stays at 00.
3. lookup_valid held high continuously while 1 update is queued → 3 lookups granted. Cycle 4: lookup_ready = 0 and the update drains. Cycle 5: lookup_ready = 1 and starve_cnt = 0.
4. Fill the queue with 4 updates while lookups hold the slot → upd_ready = 0, uq_count = 4, lookup_ready = 0. A 5th upd_valid is not accepted. After one drain: upd_ready = 1, uq_count = 3.
5. Queue update to idx 7 (taken) and lookup idx 7 in the same cycle → lookup wins, returns 0 (stale). The update applies next cycle; a following lookup of idx 7 returns 0 (counter 01). A second taken update then gives 1.
6. Assert rst asynchronously with the queue at 3 entries and a lookup in flight → immediately uq_count = 0, resp_valid = 0, upd_ready = 1. After release, all indices predict 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: counter encoding, update entry, training rule.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package bp_pkg;

  // Two-bit saturating counter states; the MSB is the taken prediction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Index width of the predictor family's history tables.
  localparam int BP_INDEX_W = 4;

  // One resolved branch outcome waiting to train the table.
  typedef struct packed {
    logic [BP_INDEX_W-1:0] index;
    logic                  taken;
  } upd_entry_t;

  // Saturating training step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] next_counter(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    case (state)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = state;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Update queue for resolved branch outcomes; power-of-two depth, wrapping pointers.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; no pass-through when full.
module bht_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage: write the tail slot on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bht_arbiter.sv
// Branch history table with one access slot shared by fetch lookups and queued updates.
// Latency: lookup response one cycle after grant; a queued update is applied in its grant cycle.
// Backpressure: lookup_ready drops when the queue is full or lookups have starved it; upd_ready = !full.
module bht_arbiter
  import bp_pkg::*;
#(
  parameter int INDEX_W    = BP_INDEX_W,
  parameter int UQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lookup_valid,
  input  logic [INDEX_W-1:0]          lookup_index,
  output logic                        lookup_ready,
  output logic                        resp_valid,
  output logic                        resp_prediction,
  input  logic                        upd_valid,
  input  logic [INDEX_W-1:0]          upd_index,
  input  logic                        upd_taken,
  output logic                        upd_ready,
  output logic [$clog2(UQ_DEPTH):0]   uq_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int SW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [1:0]         ctr_tbl [ENTRIES];
  logic [SW-1:0]      starve_cnt;
  upd_entry_t         push_ent;
  upd_entry_t         head_ent;
  logic [INDEX_W-1:0] head_idx;
  logic               uq_full;
  logic               uq_empty;
  logic               force_upd;
  logic               grant_lookup;
  logic               grant_update;
  logic               enq;

  // INDEX_W is expected to match the package index width; the casts keep widths explicit.
  always_comb begin
    push_ent       = '0;
    push_ent.index = BP_INDEX_W'(upd_index);
    push_ent.taken = upd_taken;
  end

  assign head_idx = INDEX_W'(head_ent.index);

  // Slot arbitration depends only on registered queue/starvation state, never on lookup_valid.
  assign force_upd    = !uq_empty && (uq_full || (starve_cnt == SW'(STARVE_MAX)));
  assign lookup_ready = !force_upd;
  assign grant_lookup = lookup_valid && lookup_ready;
  assign grant_update = !uq_empty && !grant_lookup;
  assign upd_ready    = !uq_full;
  assign enq          = upd_valid && upd_ready;

  bht_upd_fifo #(
    .DEPTH (UQ_DEPTH),
    .W     ($bits(upd_entry_t))
  ) u_upd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data (push_ent),
    .pop       (grant_update),
    .pop_data  (head_ent),
    .full      (uq_full),
    .empty     (uq_empty),
    .count     (uq_count)
  );

  // Counter array: read-modify-write of the popped entry's counter in the update grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_tbl[i] <= SNT;
    end else if (grant_update) begin
      ctr_tbl[head_idx] <= next_counter(ctr_tbl[head_idx], head_ent.taken);
    end
  end

  // Lookup response: pulse valid after a grant; the prediction holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid      <= 1'b0;
      resp_prediction <= 1'b0;
    end else begin
      resp_valid <= grant_lookup;
      if (grant_lookup) resp_prediction <= ctr_tbl[lookup_index][1];
    end
  end

  // Starvation guard: count lookups that win while updates wait; any drain or empty queue clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (uq_empty || grant_update) begin
      starve_cnt <= '0;
    end else if (grant_lookup && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_bht_arbiter.sv
// Randomized and directed bench for bht_arbiter against a queue-based reference model.
// Latency: model predicts every registered output one cycle ahead of the DUT edge.
// Backpressure: model tracks queue occupancy and the starvation rule to predict both readies.
module tb_bht_arbiter;

  localparam int IW    = 4;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;
  localparam int NENT  = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_valid;
  logic [IW-1:0] lookup_index;
  logic          lookup_ready;
  logic          resp_valid;
  logic          resp_prediction;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic          upd_taken;
  logic          upd_ready;
  logic [2:0]    uq_count;

  always #5 clk = ~clk;

  bht_arbiter #(.INDEX_W(IW), .UQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid    (lookup_valid),
    .lookup_index    (lookup_index),
    .lookup_ready    (lookup_ready),
    .resp_valid      (resp_valid),
    .resp_prediction (resp_prediction),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_taken       (upd_taken),
    .upd_ready       (upd_ready),
    .uq_count        (uq_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: counters as integers 0..3, pending updates as a plain queue.
  typedef struct { int idx; int tkn; } ent_t;
  int   m_ctr [NENT];
  ent_t m_q [$];
  int   m_starve;
  int   m_rv;
  int   m_rp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_ctr[i] = 0;
    m_q.delete();
    m_starve = 0;
    m_rv     = 0;
    m_rp     = 0;
  endtask

  function automatic int m_lookup_ready();
    return !((m_q.size() > 0) && ((m_q.size() == DEPTH) || (m_starve == SMAX)));
  endfunction

  // Compare all outputs against the model, then advance the model across the coming edge.
  task automatic check_and_model();
    int   lr, ur, lk, up, was_empty;
    ent_t e;
    lr = m_lookup_ready();
    ur = (m_q.size() != DEPTH);
    check_eq("lookup_ready", lookup_ready, lr);
    check_eq("upd_ready", upd_ready, ur);
    check_eq("uq_count", uq_count, m_q.size());
    check_eq("resp_valid", resp_valid, m_rv);
    check_eq("resp_prediction", resp_prediction, m_rp);

    lk        = lookup_valid && lr;
    up        = !lk && (m_q.size() > 0);
    was_empty = (m_q.size() == 0);
    m_rv      = lk;
    if (lk) m_rp = (m_ctr[lookup_index] >= 2);
    if (up) begin
      e = m_q.pop_front();
      if (e.tkn != 0) m_ctr[e.idx] = (m_ctr[e.idx] == 3) ? 3 : m_ctr[e.idx] + 1;
      else            m_ctr[e.idx] = (m_ctr[e.idx] == 0) ? 0 : m_ctr[e.idx] - 1;
    end
    if (was_empty || up) m_starve = 0;
    else if (lk)         m_starve = (m_starve == SMAX) ? SMAX : m_starve + 1;
    if (upd_valid && ur) begin
      e.idx = upd_index;
      e.tkn = upd_taken;
      m_q.push_back(e);
    end
  endtask

  // One clock: drive inputs just after the edge, check at the falling edge.
  task automatic cycle(input logic lv, input logic [IW-1:0] li,
                       input logic uv, input logic [IW-1:0] ui, input logic ut);
    lookup_valid = lv;
    lookup_index = li;
    upd_valid    = uv;
    upd_index    = ui;
    upd_taken    = ut;
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic upd(input logic [IW-1:0] i, input logic t);
    cycle(1'b0, '0, 1'b1, i, t);
  endtask

  task automatic look(input logic [IW-1:0] i);
    cycle(1'b1, i, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    lookup_valid = 1'b0;
    lookup_index = '0;
    upd_valid    = 1'b0;
    upd_index    = '0;
    upd_taken    = 1'b0;
    model_reset();
    #12;
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_prediction", resp_prediction, 0);
    check_eq("rst_uq_count", uq_count, 0);
    check_eq("rst_upd_ready", upd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain lookup after reset predicts not-taken one cycle later.
    look(4'd5);
    check_eq("t1_resp_valid", resp_valid, 1);
    check_eq("t1_resp_prediction", resp_prediction, 0);
    idle(1);

    // Training and saturation on index 3.
    upd(4'd3, 1'b1);
    upd(4'd3, 1'b1);
    idle(2);
    look(4'd3);
    check_eq("t2_taken_pred", resp_prediction, 1);
    for (int i = 0; i < 4; i++) upd(4'd3, 1'b1);
    idle(2);
    for (int i = 0; i < 5; i++) upd(4'd3, 1'b0);
    idle(2);
    look(4'd3);
    check_eq("t2_sat_low_pred", resp_prediction, 0);
    idle(1);

    // Starvation guard with lookups held continuously.
    upd(4'd9, 1'b1);
    for (int i = 0; i < 6; i++) look(4'd2);
    idle(2);

    // Queue fills while lookups hold the slot; extra offers are refused.
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'(i), 1'b1, 4'(i + 8), 1'b1);
    idle(5);

    // Same-cycle lookup and update on index 7: lookup sees the stale value.
    cycle(1'b1, 4'd7, 1'b1, 4'd7, 1'b1);
    check_eq("t5_stale_pred", resp_prediction, 0);
    idle(1);
    look(4'd7);
    check_eq("t5_weak_nt_pred", resp_prediction, 0);
    upd(4'd7, 1'b1);
    idle(1);
    look(4'd7);
    check_eq("t5_weak_t_pred", resp_prediction, 1);
    idle(1);

    // Asynchronous reset with queued entries and a response in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd1, 1'b1, 4'(i), 1'b1);
    look(4'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_uq_count", uq_count, 0);
    check_eq("t6_resp_valid", resp_valid, 0);
    check_eq("t6_upd_ready", upd_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NENT; i++) look(4'(i));
    idle(1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      cycle(1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, NENT - 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, NENT - 1)),
            1'($urandom_range(0, 1)));
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
